// File: rtl/pinky_mmio_pkg.sv
// Shared MMIO definitions for the pinky peripherals: UART register indices,
// STATUS bit positions and the UART transmit/receive FSM state encodings.
package pinky_mmio_pkg;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_RXDATA = 2'd1;
  localparam logic [1:0] UART_REG_STATUS = 2'd2;

  localparam int UART_ST_TX_BUSY   = 0;
  localparam int UART_ST_RX_VALID  = 1;
  localparam int UART_ST_RX_FULL   = 2;
  localparam int UART_ST_OVERRUN   = 3;
  localparam int UART_ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/uart_mmio_rx_fifo.sv
// Receive FIFO for uart_mmio: byte-wide, DEPTH entries (power of two, >= 2).
// A pop on empty is ignored; a push when full only lands if a pop frees a slot.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXDATA / RXDATA / STATUS registers at address[3:2].
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO; otherwise a
// single-byte holding register buffers received data.
//
// TX state | meaning
// IDLE     | line high, waiting for a TXDATA write
// START    | driving the start bit (low)
// DATA     | shifting out 8 data bits, LSB first
// STOP     | driving the stop bit (high)
//
// RX state | meaning
// IDLE     | waiting for a falling edge on the synchronized line
// START    | waiting to half-bit to confirm the start bit
// DATA     | sampling 8 data bits at mid-bit
// STOP     | sampling the stop bit, then push or flag frame error
module uart_mmio
  import pinky_mmio_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int BAUD          = 115_200,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        rxd,
  output logic        txd
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

`ifdef UART_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic [1:0] reg_idx;
  logic       tx_wr;
  logic       pop_req;
  logic       status_wr;
  logic       unused_bits;

  assign reg_idx     = address[3:2];
  assign tx_wr       = write_en && (reg_idx == UART_REG_TXDATA);
  assign pop_req     = write_en && (reg_idx == UART_REG_RXDATA);
  assign status_wr   = write_en && (reg_idx == UART_REG_STATUS);
  assign unused_bits = ^{address[31:4], address[1:0], write_data[31:8]};

  // ---------------- transmitter ----------------
  uart_tx_state_t tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;
  logic           tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_shift <= write_data[7:0];
            tx_cnt   <= BIT_LAST;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  uart_rx_state_t rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic           rx_s1;
  logic           rx_s2;
  logic           rx_prev;
  logic           rx_stop_sample;
  logic           rx_push;
  logic           frame_err_set;

  assign rx_stop_sample = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_push        = rx_stop_sample && rx_s2;
  assign frame_err_set  = rx_stop_sample && !rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            // A line that is high again at half-bit was only a glitch.
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- receive buffer ----------------
  logic [7:0] rx_head;
  logic       rx_valid;
  logic       rx_full;
  logic       pop_eff;
  logic       overrun_set;

  assign pop_eff     = pop_req && rx_valid;
  assign overrun_set = rx_push && rx_full && !pop_eff;

  generate
    if (FIFO_EN) begin : g_fifo
      logic fifo_full;
      logic fifo_empty;

      uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
      ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (pop_req),
        .din   (rx_shift),
        .head  (rx_head),
        .full  (fifo_full),
        .empty (fifo_empty)
      );

      assign rx_valid = !fifo_empty;
      assign rx_full  = fifo_full;
    end else begin : g_hold
      logic [7:0] hold_data;
      logic       hold_valid;

      // On overflow the held byte is kept; the new one is dropped.
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_valid <= 1'b0;
          hold_data  <= '0;
        end else begin
          if (pop_eff) hold_valid <= 1'b0;
          if (rx_push && (!hold_valid || pop_eff)) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_shift;
          end
        end
      end

      assign rx_head  = hold_data;
      assign rx_valid = hold_valid;
      assign rx_full  = hold_valid;
    end
  endgenerate

  // ---------------- sticky flags ----------------
  logic overrun;
  logic frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set ||
                   (overrun && !(status_wr && write_data[UART_ST_OVERRUN]));
      frame_err <= frame_err_set ||
                   (frame_err && !(status_wr && write_data[UART_ST_FRAME_ERR]));
    end
  end

  // ---------------- register read ----------------
  logic [4:0] status;

  always_comb begin
    status                    = '0;
    status[UART_ST_TX_BUSY]   = tx_busy;
    status[UART_ST_RX_VALID]  = rx_valid;
    status[UART_ST_RX_FULL]   = rx_full;
    status[UART_ST_OVERRUN]   = overrun;
    status[UART_ST_FRAME_ERR] = frame_err;
  end

  always_comb begin
    read_data = '0;
    case (reg_idx)
      UART_REG_RXDATA: if (rx_valid) read_data = {24'b0, rx_head};
      UART_REG_STATUS: read_data = {27'b0, status};
      default:         read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio at BIT_CYCLES=10: register probes and TX
// frames are queued with expected values and checked by separate monitors.
module tb_uart_mmio;

`ifdef UART_RX_FIFO_EN
  localparam int D = 16;
`else
  localparam int D = 1;
`endif
  localparam int BC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        rxd;
  logic        txd;

  uart_mmio #(
    .CLK_FREQ_HZ   (100_000_000),
    .BAUD          (10_000_000),
    .RX_FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write_en   (write_en),
    .write_data (write_data),
    .read_data  (read_data),
    .rxd        (rxd),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // expected-response queues
  string       nq[$];
  logic [31:0] vq[$];
  logic [7:0]  tx_exp[$];
  logic        probe;
  logic        tx_mon_en;

  // reference model of the receive side
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, m_ferr, m_ovr, (mq.size() == D), (mq.size() != 0), 1'b0};
  endfunction

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    address = a; write_data = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic probe_rd(input string nm, input logic [31:0] a, input logic [31:0] e,
                          input bit pop);
    address = a;
    nq.push_back(nm);
    vq.push_back(e);
    probe = 1'b1;
    write_en = pop;
    write_data = $urandom;
    @(negedge clk);
    probe = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic probe_status(input string nm);
    probe_rd(nm, 32'h8, m_status(), 1'b0);
  endtask

  task automatic pop_chk(input string nm);
    logic [31:0] e;
    e = (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
    probe_rd(nm, 32'h4, e, 1'b1);
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic wr_status(input logic [31:0] v);
    mmio_wr(32'h8, v);
    if (v[3]) m_ovr = 1'b0;
    if (v[4]) m_ferr = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input bit stop);
    rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BC) @(negedge clk);
    end
    rxd = stop;
    repeat (BC) @(negedge clk);
    rxd = 1'b1;
    repeat (BC) @(negedge clk);
    if (stop) begin
      if (mq.size() < D) mq.push_back(b);
      else               m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wait_tx_idle();
    bit done;
    done = 1'b0;
    address = 32'h8;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (!read_data[0]) begin done = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    chk("tx_idle_reached", {31'b0, done}, 32'd1);
  endtask

  // register probe monitor
  initial begin
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (probe) begin
        if (vq.size() == 0) begin
          chk("probe_without_expectation", 32'd1, 32'd0);
        end else begin
          e = vq.pop_front();
          n = nq.pop_front();
          chk(n, read_data, e);
        end
      end
    end
  end

  // TX line monitor: captures 10 bits x 10 cycles after each start edge
  initial begin
    logic [99:0] smp;
    logic [9:0]  f;
    logic [9:0]  act;
    logic [7:0]  eb;
    int          bad;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !reset && txd == 1'b0) begin
        smp[0] = txd;
        for (int i = 1; i < 100; i++) begin
          @(negedge clk);
          smp[i] = txd;
        end
        if (tx_exp.size() == 0) begin
          chk("tx_unexpected_frame", 32'd1, 32'd0);
        end else begin
          eb  = tx_exp.pop_front();
          f   = {1'b1, eb, 1'b0};
          bad = 0;
          for (int i = 0; i < 100; i++) if (smp[i] !== f[i / 10]) bad++;
          for (int k = 0; k < 10; k++) act[k] = smp[k * 10 + 5];
          chk("tx_frame", {bad[15:0], 6'b0, act}, {22'b0, f});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [7:0] b;
    clk = 1'b0; reset = 1'b1; address = '0; write_data = '0; write_en = 1'b0;
    rxd = 1'b1; probe = 1'b0; tx_mon_en = 1'b1;
    m_ovr = 1'b0; m_ferr = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_txd", {31'b0, txd}, 32'd1);
    for (int a = 0; a < 4; a++) probe_rd("reset_reg", a * 4, 32'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // TX 0x55: busy width and line pattern
    tx_exp.push_back(8'h55);
    mmio_wr(32'h0, 32'h55);
    address = 32'h8;
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (read_data[0]) busy_cnt++;
      else break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("tx_busy_cycles", busy_cnt, 32'd100);

    // a write while busy is ignored
    b = 8'($urandom_range(0, 255));
    tx_exp.push_back(b);
    mmio_wr(32'h0, {24'b0, b});
    repeat (30) @(negedge clk);
    mmio_wr(32'h0, {24'b0, ~b});
    wait_tx_idle();

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_exp.push_back(b);
      mmio_wr(32'h0, {24'b0, b});
      wait_tx_idle();
    end

    // single RX byte
    rx_send(8'hA3, 1'b1);
    probe_status("status_after_a3");
    probe_rd("txdata_reads_zero", 32'h0, 32'h0, 1'b0);
    pop_chk("rxdata_a3");
    probe_status("status_after_pop");

    // fill past capacity
    for (int i = 0; i <= D; i++) rx_send(8'(i), 1'b1);
    probe_status("status_full_overrun");
    for (int i = 0; i <= D; i++) pop_chk("rxdata_fill_order");
    probe_status("status_drained");
    wr_status(32'h8);
    probe_status("status_overrun_cleared");

    // framing error leaves buffer intact
    rx_send(8'h11, 1'b1);
    rx_send(8'h5A, 1'b0);
    probe_status("status_frame_err");
    wr_status(32'h10);
    probe_status("status_frame_err_cleared");
    pop_chk("rxdata_after_frame_err");

    // glitch shorter than half a bit
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    probe_status("status_after_glitch");
    rx_send(8'h3C, 1'b1);
    pop_chk("rxdata_after_glitch");

    // reserved register
    mmio_wr(32'hC, $urandom);
    probe_rd("reserved_reads_zero", 32'hC, 32'h0, 1'b0);

    // randomized receive traffic with interleaved pops and flag clears
    for (int i = 0; i < 24; i++) begin
      rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 1) == 0) pop_chk("rxdata_random");
      if ($urandom_range(0, 3) == 0) probe_status("status_random");
      if ($urandom_range(0, 5) == 0) wr_status({27'b0, 5'($urandom_range(0, 31))});
    end
    probe_status("status_random_end");
    while (mq.size() != 0) pop_chk("rxdata_random_drain");
    pop_chk("rxdata_empty_pop");

    // reset in the middle of a TX frame with data buffered
    rx_send(8'h77, 1'b1);
    tx_mon_en = 1'b0;
    mmio_wr(32'h0, 32'h00);
    repeat (40) @(negedge clk);
    chk("txd_low_before_reset", {31'b0, txd}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("txd_after_reset", {31'b0, txd}, 32'd1);
    reset = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    probe_status("status_after_reset");
    probe_rd("rxdata_after_reset", 32'h4, 32'h0, 1'b0);
    tx_mon_en = 1'b1;
    b = 8'($urandom_range(0, 255));
    tx_exp.push_back(b);
    mmio_wr(32'h0, {24'b0, b});
    wait_tx_idle();

    repeat (5) @(negedge clk);
    chk("tx_queue_drained", tx_exp.size(), 32'd0);
    chk("probe_queue_drained", vq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped 8N1 UART peripheral that sits directly downstream of `memory_mapper` on its MMIO port. It drives `in_mmio_read_data` and consumes `out_mmio_address`, `out_mmio_write_data`, `out_mmio_write_en` and `out_mmio_reset`. It connects the board `TxD`/`RxD` pins to the CPU through a transmit holding path, a receive FIFO and a status register.

## Interface
- `CLK_FREQ_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 115_200, line rate; bit period `BIT_CYCLES = CLK_FREQ_HZ / BAUD` (integer, truncated, must be ≥ 4).
- `RX_FIFO_DEPTH`, 16, receive FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock. One clock only.
- `reset`  in  1  synchronous, active-high; driven from `out_mmio_reset`.
- `address`  in  32  byte offset within the MMIO window; only `address[3:2]` is decoded.
- `write_en`  in  1  write strobe, one cycle per access.
- `write_data`  in  32  write data.
- `read_data`  out  32  combinational read of the addressed register; reads have no side effects.
- `rxd`  in  1  asynchronous serial input.
- `txd`  out  1  serial output; idle high.

## Operation
- Register map, indexed by `address[3:2]`:
  - 0 = TXDATA. A write with `tx_busy`=0 latches `write_data[7:0]` and starts a frame. A write while busy is ignored. Reads return 0.
  - 1 = RXDATA. Reads return `{24'b0, fifo_head}`, or 0 when empty. A write of any value pops one entry; a pop on an empty FIFO is ignored.
  - 2 = STATUS.
    - bit0 `tx_busy`, bit1 `rx_valid` (not empty), bit2 `rx_full`, bit3 `overrun` (sticky), bit4 `frame_err` (sticky).
    - A write of 1 to bit3 or bit4 clears that bit.
  - 3 = reserved; reads 0, writes ignored.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE. Each state holds for `BIT_CYCLES`.
- RX path:
  - `rxd` passes through a 2-flop synchronizer.
  - RX FSM: IDLE → START → DATA → STOP.
  - A falling edge in IDLE enters START. START checks the line at `BIT_CYCLES/2`: if high, it is treated as a glitch and the FSM returns to IDLE. If low, the FSM moves to DATA.
  - Each data bit and the stop bit are sampled `BIT_CYCLES` apart, at mid-bit.
  - Stop bit = 1: push the byte. Stop bit = 0: set `frame_err` and discard the byte.
- FIFO rules:
  - Push when full: drop the byte and set `overrun`.
  - Push and pop in the same cycle when full: both occur, and `overrun` is not set.
  - Push and pop in the same cycle when empty: the pop is ignored and the push succeeds.
  - Read/write pointers are `$clog2(RX_FIFO_DEPTH)+1` bits wide and wrap modulo 2×depth. full/empty are derived from the MSB plus pointer equality.
- Sticky flags:
  - Set has priority over a clear in the same cycle.
  - A TXDATA write while busy does not flag anything.

## Timing
- Reset values: `txd`=1; both FSMs in IDLE; FIFO empty; `overrun`=`frame_err`=0; `read_data` = 0 for every address except STATUS, which reads 0.
- TX latency: a write accepted at edge N gives `txd`=0 and `tx_busy`=1 from edge N+1. A frame lasts 10×`BIT_CYCLES` cycles. `tx_busy` falls on the edge that ends the stop bit, so a new write is accepted in that same cycle.
- RX latency:
  - Synchronizer delay is 2 cycles.
  - The byte is pushed on the edge at the stop-bit mid-sample, i.e. about 9.5×`BIT_CYCLES`+2 cycles after the line's falling edge.
  - `rx_valid` is visible on `read_data` the next cycle.
- `read_data` is a combinational function of `address` and current state; a pop takes effect on the edge of the write.
- Reset mid-frame aborts both FSMs immediately. `txd` returns high on the next edge and the FIFO contents are discarded.

## Configuration
- `UART_RX_FIFO_EN` defined: the receive buffer is an `RX_FIFO_DEPTH`-entry FIFO as described.
- Not defined: the buffer is a single-byte holding register.
  - `rx_full` == `rx_valid`.
  - A push while valid sets `overrun` and keeps the old byte.
  - `RX_FIFO_DEPTH` is ignored.

## Structure
- The shared package `pinky_mmio_pkg` holds:
  - register index constants `UART_REG_TXDATA`/`RXDATA`/`STATUS`;
  - STATUS bit positions;
  - the FSM state enums `uart_tx_state_t` and `uart_rx_state_t`.
- Sub-module `uart_rx_fifo`: the synchronous FIFO with push, pop, head, full and empty. It is bypassed in favour of the holding register when `UART_RX_FIFO_EN` is off.

## Test plan
All scenarios use `CLK_FREQ_HZ`=100_000_000 and `BAUD`=10_000_000, so `BIT_CYCLES`=10.
- Write 0x55 to TXDATA after reset → `txd` pattern 0,1,0,1,0,1,0,1,0,1 with 10 cycles per bit; `tx_busy` high for exactly 100 cycles; a second write during the frame is ignored.
- Drive 0xA3 on `rxd` → STATUS bit1=1 and RXDATA reads 0x000000A3; write RXDATA → STATUS bit1=0.
- Receive 17 bytes 0x00..0x10 with no pops → STATUS bit2=1, bit3=1; popping returns 0x00..0x0F in order, and 0x10 is lost.
- Frame with stop bit 0 → STATUS bit4=1 and FIFO unchanged; write 0x10 to STATUS → bit4=0.
- 3-cycle low glitch on `rxd` → no push and RX returns to IDLE.
- Assert `reset` at cycle 40 of a TX frame → `txd`=1 next cycle, `tx_busy`=0, FIFO empty.
